barrel_shift_register: RTL and testbench

BARREL_SHIFT_REGISTER -- requirements
Module: barrel_shift_register

---
 rtl/shift_pkg.sv | 40 ++++
 rtl/barrel_rotator.sv | 36 +++
 rtl/barrel_shift_register.sv | 138 +++++++++++++
 tb/tb_barrel_shift_register.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the barrel shift register: operation codes,
// control states and rotator modes.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_SHL   = 3'b001,
    OP_SHR   = 3'b010,
    OP_LOAD  = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_BURST = 3'b111
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ROT_LEFT  = 2'b00,
    ROT_RIGHT = 2'b01,
    ROT_ASR   = 2'b10,
    ROT_NONE  = 2'b11
  } rot_mode_t;

  // Map an opcode onto the rotator mode it needs; non-rotator ops get ROT_NONE.
  function automatic rot_mode_t op_to_mode(input logic [2:0] op);
    rot_mode_t mode;
    case (op)
      OP_ROL:  mode = ROT_LEFT;
      OP_ROR:  mode = ROT_RIGHT;
      OP_ASR:  mode = ROT_ASR;
      default: mode = ROT_NONE;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/barrel_rotator.sv
// Combinational rotate-left / rotate-right / arithmetic-right-shift datapath.
// The amount is log2(WIDTH) bits wide, so rotation is naturally modulo WIDTH.
module barrel_rotator
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   result
);

  localparam logic [SHAMT_W:0] W_L = (SHAMT_W+1)'(WIDTH);

  logic [SHAMT_W:0]         w_inv;
  logic [WIDTH-1:0]         w_rol;
  logic [WIDTH-1:0]         w_ror;
  logic signed [WIDTH-1:0]  w_asr;

  // Shifting by WIDTH-amount yields zero when amount is zero, so no special case.
  always_comb begin
    w_inv  = W_L - {1'b0, amount};
    w_rol  = (data << amount) | (data >> w_inv);
    w_ror  = (data >> amount) | (data << w_inv);
    w_asr  = $signed(data) >>> amount;
    case (rot_mode_t'(mode))
      ROT_LEFT:  result = w_rol;
      ROT_RIGHT: result = w_ror;
      ROT_ASR:   result = w_asr;
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/barrel_shift_register.sv
// Shift register with single-cycle shift/rotate/load operations and a
// multi-cycle serial burst mode sequenced by a two-state controller.
module barrel_shift_register
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               l_in,
  input  logic               r_in,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q,
  output logic               so,
  output logic               busy,
  output logic               done
);

  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [WIDTH-1:0]   r_q;
  logic               r_so;
  logic               r_busy;
  logic               r_done;
  logic [SHAMT_W-1:0] r_count;

  state_t             w_state_next;
  logic [WIDTH-1:0]   w_q_next;
  logic               w_so_next;
  logic               w_done_next;
  logic [SHAMT_W-1:0] w_count_next;
  logic [1:0]         w_rot_mode;
  logic [WIDTH-1:0]   w_rot_result;

  assign w_rot_mode = op_to_mode(op);

  barrel_rotator #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_rotator (
    .data   (r_q),
    .amount (shamt),
    .mode   (w_rot_mode),
    .result (w_rot_result)
  );

  // Next-state and datapath selection; commands are only decoded in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_so_next    = r_so;
    w_done_next  = 1'b0;
    w_count_next = r_count;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          case (op_t'(op))
            OP_HOLD: begin
              w_q_next = r_q;
            end
            OP_SHL: begin
              w_q_next  = {r_q[WIDTH-2:0], r_in};
              w_so_next = r_q[WIDTH-1];
            end
            OP_SHR: begin
              w_q_next  = {l_in, r_q[WIDTH-1:1]};
              w_so_next = r_q[0];
            end
            OP_LOAD: begin
              w_q_next = d;
            end
            OP_ROL, OP_ROR, OP_ASR: begin
              w_q_next = w_rot_result;
            end
            OP_BURST: begin
              if (shamt != CNT_ZERO) begin
                w_state_next = ST_RUN;
                w_count_next = shamt;
              end else begin
                w_done_next = 1'b1;
              end
            end
            default: begin
              w_q_next = r_q;
            end
          endcase
        end else begin
          w_q_next = r_q;
        end
      end
      ST_RUN: begin
        w_q_next     = {r_q[WIDTH-2:0], r_in};
        w_so_next    = r_q[WIDTH-1];
        w_count_next = r_count - CNT_ONE;
        if (r_count == CNT_ONE) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; clr wins over any pending command or burst.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_so    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_so    <= w_so_next;
      r_busy  <= (w_state_next == ST_RUN);
      r_done  <= w_done_next;
      r_count <= w_count_next;
    end
  end

  assign q    = r_q;
  assign so   = r_so;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_barrel_shift_register.sv
// Directed scoreboard bench for barrel_shift_register at WIDTH=8.
module tb_barrel_shift_register;

  logic       clk;
  logic       clr;
  logic       en;
  logic [2:0] op;
  logic [2:0] shamt;
  logic       l_in;
  logic       r_in;
  logic [7:0] d;
  logic [7:0] q;
  logic       so;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       so;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  barrel_shift_register #(.WIDTH(8)) dut (
    .clk   (clk),
    .clr   (clr),
    .en    (en),
    .op    (op),
    .shamt (shamt),
    .l_in  (l_in),
    .r_in  (r_in),
    .d     (d),
    .q     (q),
    .so    (so),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      checks++;
      assert (q === e.q) else begin
        failures++;
        $error("FAIL %s.q observed=%h expected=%h", e.tag, q, e.q);
      end
      checks++;
      assert (so === e.so) else begin
        failures++;
        $error("FAIL %s.so observed=%b expected=%b", e.tag, so, e.so);
      end
      checks++;
      assert (busy === e.busy) else begin
        failures++;
        $error("FAIL %s.busy observed=%b expected=%b", e.tag, busy, e.busy);
      end
      checks++;
      assert (done === e.done) else begin
        failures++;
        $error("FAIL %s.done observed=%b expected=%b", e.tag, done, e.done);
      end
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic c, input logic e, input logic [2:0] o,
                      input logic [2:0] s, input logic [7:0] dd, input logic li, input logic ri,
                      input logic [7:0] eq, input logic eso, input logic ebusy, input logic edone);
    exp_t x;
    clr   = c;
    en    = e;
    op    = o;
    shamt = s;
    d     = dd;
    l_in  = li;
    r_in  = ri;
    x.tag  = tag;
    x.q    = eq;
    x.so   = eso;
    x.busy = ebusy;
    x.done = edone;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr = 1'b1; en = 1'b0; op = 3'b000; shamt = 3'd0; d = 8'h00; l_in = 1'b0; r_in = 1'b0;
    //    tag            clr   en    op      sh    d       l     r       q      so    busy  done
    step("reset",        1'b1, 1'b1, 3'b011, 3'd0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step("hold_op",      1'b0, 1'b1, 3'b000, 3'd0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step("load_b4",      1'b0, 1'b1, 3'b011, 3'd0, 8'hB4, 1'b0, 1'b0, 8'hB4, 1'b0, 1'b0, 1'b0);
    step("rol3",         1'b0, 1'b1, 3'b100, 3'd3, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    step("ror3",         1'b0, 1'b1, 3'b101, 3'd3, 8'h00, 1'b0, 1'b0, 8'hB4, 1'b0, 1'b0, 1'b0);
    step("rol0",         1'b0, 1'b1, 3'b100, 3'd0, 8'h00, 1'b0, 1'b0, 8'hB4, 1'b0, 1'b0, 1'b0);
    step("asr0",         1'b0, 1'b1, 3'b110, 3'd0, 8'h00, 1'b0, 1'b0, 8'hB4, 1'b0, 1'b0, 1'b0);
    step("load_96",      1'b0, 1'b1, 3'b011, 3'd0, 8'h96, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
    step("asr2_neg",     1'b0, 1'b1, 3'b110, 3'd2, 8'h00, 1'b0, 1'b0, 8'hE5, 1'b0, 1'b0, 1'b0);
    step("load_16",      1'b0, 1'b1, 3'b011, 3'd0, 8'h16, 1'b0, 1'b0, 8'h16, 1'b0, 1'b0, 1'b0);
    step("asr2_pos",     1'b0, 1'b1, 3'b110, 3'd2, 8'h00, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);
    step("load_81",      1'b0, 1'b1, 3'b011, 3'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    step("shl1",         1'b0, 1'b1, 3'b001, 3'd0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0);
    step("so_kept_rol",  1'b0, 1'b1, 3'b100, 3'd4, 8'h00, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0);
    step("ror4_back",    1'b0, 1'b1, 3'b101, 3'd4, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0);
    step("shr1",         1'b0, 1'b1, 3'b010, 3'd0, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    step("en_low_hold",  1'b0, 1'b0, 3'b011, 3'd5, 8'h55, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    // Burst of 4 from F0 with r_in=1; commands while busy must be ignored.
    step("load_f0",      1'b0, 1'b1, 3'b011, 3'd0, 8'hF0, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    step("burst4_cmd",   1'b0, 1'b1, 3'b111, 3'd4, 8'h00, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
    step("burst4_s1",    1'b0, 1'b1, 3'b011, 3'd0, 8'h00, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b1, 1'b0);
    step("burst4_s2",    1'b0, 1'b1, 3'b100, 3'd3, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
    step("burst4_s3",    1'b0, 1'b1, 3'b111, 3'd2, 8'h00, 1'b0, 1'b1, 8'h87, 1'b1, 1'b1, 1'b0);
    step("burst4_s4",    1'b0, 1'b1, 3'b011, 3'd0, 8'h00, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1);
    step("cmd_in_done",  1'b0, 1'b1, 3'b011, 3'd0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    step("burst0_cmd",   1'b0, 1'b1, 3'b111, 3'd0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    step("burst0_after", 1'b0, 1'b0, 3'b000, 3'd0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    // Burst of 5 aborted by clr on its second shift cycle.
    step("burst5_cmd",   1'b0, 1'b1, 3'b111, 3'd5, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0);
    step("burst5_s1",    1'b0, 1'b0, 3'b000, 3'd0, 8'h00, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0);
    step("burst5_clr",   1'b1, 1'b1, 3'b011, 3'd0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("load_3c",      1'b0, 1'b1, 3'b011, 3'd0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    step("no_late_done", 1'b0, 1'b0, 3'b000, 3'd0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    step("rol7",         1'b0, 1'b1, 3'b100, 3'd7, 8'h00, 1'b0, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
    step("asr7_pos",     1'b0, 1'b1, 3'b110, 3'd7, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
